// File: rtl/timer_bank_if.sv
// Processor-bridge bus bundle for timer_bank: byte address, write strobe and data,
// plus the combinational read-data return path.
interface timer_bank_if;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output we, output wdata, input rdata);
  modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/timer_bank.sv
// Bank of NCH independent 32-bit down-counting timers with one-shot/auto-reload modes,
// sticky W1C pending flags and maskable level interrupts, mapped at BASE + i*STRIDE.
module timer_bank #(
  parameter logic [31:0] BASE   = 32'h0000_7F00,
  parameter logic [31:0] STRIDE = 32'h0000_0010,
  parameter int          NCH    = 2
) (
  input  logic           clk,
  input  logic           reset,
  timer_bank_if.slave    bus,
  output logic [NCH-1:0] irq
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  logic [31:0] rd_ch [NCH];

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      localparam logic [31:0] CH_BASE = BASE + STRIDE * gi;

      logic [31:0] offset;
      logic        hit;
      logic [1:0]  sel;
      logic        ctrl_wr;
      logic        preset_wr;
      logic        reload;

      logic        en_reg;
      logic        im_reg;
      logic        pend_reg;
      logic [1:0]  mode_reg;
      logic [1:0]  state_reg;
      logic [31:0] preset_reg;
      logic [31:0] count_reg;

      // Window is 12 bytes: CTRL, PRESET, COUNT; the fourth word is a miss.
      assign offset    = bus.addr - CH_BASE;
      assign hit       = (bus.addr >= CH_BASE) && (offset <= 32'h0000_000B);
      assign sel       = offset[3:2];
      assign ctrl_wr   = hit && bus.we && (sel == 2'd0);
      assign preset_wr = hit && bus.we && (sel == 2'd1);
      assign reload    = (mode_reg == 2'b01);

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          en_reg     <= 1'b0;
          im_reg     <= 1'b0;
          pend_reg   <= 1'b0;
          mode_reg   <= 2'b00;
          state_reg  <= ST_IDLE;
          preset_reg <= 32'h0;
          count_reg  <= 32'h0;
        end else begin
          if (preset_wr) begin
            preset_reg <= bus.wdata;
          end
          if (ctrl_wr) begin
            en_reg   <= bus.wdata[0];
            mode_reg <= bus.wdata[2:1];
            im_reg   <= bus.wdata[3];
            if (bus.wdata[4]) begin
              pend_reg <= 1'b0;
            end
          end
          // FSM assignments come last so expiry beats W1C and the one-shot stop beats a re-enable.
          if (!en_reg) begin
            state_reg <= ST_IDLE;
          end else begin
            case (state_reg)
              ST_IDLE: state_reg <= ST_LOAD;
              ST_LOAD: begin
                count_reg <= preset_reg;
                state_reg <= ST_CNT;
              end
              ST_CNT: begin
                if (count_reg != 32'h0) begin
                  count_reg <= count_reg - 32'h1;
                end else begin
                  state_reg <= ST_INT;
                  pend_reg  <= 1'b1;
                end
              end
              default: begin
                if (reload) begin
                  state_reg <= ST_LOAD;
                end else begin
                  state_reg <= ST_IDLE;
                  en_reg    <= 1'b0;
                end
              end
            endcase
          end
        end
      end

      assign rd_ch[gi] = !hit          ? 32'h0 :
                         (sel == 2'd0) ? {27'h0, pend_reg, im_reg, mode_reg, en_reg} :
                         (sel == 2'd1) ? preset_reg :
                         (sel == 2'd2) ? count_reg : 32'h0;

      assign irq[gi] = pend_reg & im_reg;
    end
  endgenerate

  // Channel windows never overlap, so at most one term is nonzero.
  always_comb begin
    bus.rdata = 32'h0;
    for (int i = 0; i < NCH; i++) begin
      bus.rdata = bus.rdata | rd_ch[i];
    end
  end

endmodule

// File: tb/tb_timer_bank.sv
// Randomised scoreboard bench for timer_bank against a timeline-based reference model.
module tb_timer_bank;
  localparam logic [31:0] BASE   = 32'h0000_7F00;
  localparam logic [31:0] STRIDE = 32'h0000_0010;
  localparam int          NCH    = 3;

  logic           clk;
  logic           reset;
  logic [NCH-1:0] irq;

  timer_bank_if bus();

  timer_bank #(.BASE(BASE), .STRIDE(STRIDE), .NCH(NCH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: register contents plus, per running channel, the edge at which
  // COUNT is loaded; expiry is load+N+1, reload/stop decision at load+N+2.
  logic        m_en     [NCH];
  logic        m_im     [NCH];
  logic        m_pend   [NCH];
  logic [1:0]  m_mode   [NCH];
  logic [31:0] m_preset [NCH];
  logic [31:0] m_count  [NCH];
  bit          m_active [NCH];
  longint      m_tload  [NCH];
  longint      m_n      [NCH];
  longint      t_edge;

  typedef struct {
    logic [31:0]    addr;
    logic           we;
    logic [31:0]    rd;
    logic [NCH-1:0] irq;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   ntx   = 0;

  function automatic longint ch_base(input int ch);
    return longint'(BASE) + longint'(ch) * longint'(STRIDE);
  endfunction

  function automatic int chan_of(input logic [31:0] a);
    longint la = longint'(a);
    for (int i = 0; i < NCH; i++) begin
      if (la >= ch_base(i) && la <= ch_base(i) + 11) return i;
    end
    return -1;
  endfunction

  function automatic int reg_of(input logic [31:0] a, input int ch);
    return int'((longint'(a) - ch_base(ch)) / 4);
  endfunction

  function automatic logic [31:0] ra(input int ch, input int r);
    return 32'(ch_base(ch) + 4 * r);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int ch = chan_of(a);
    if (ch < 0) return 32'h0;
    case (reg_of(a, ch))
      0:       return {27'h0, m_pend[ch], m_im[ch], m_mode[ch], m_en[ch]};
      1:       return m_preset[ch];
      2:       return m_count[ch];
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [NCH-1:0] model_irq();
    logic [NCH-1:0] v = '0;
    for (int i = 0; i < NCH; i++) v[i] = m_pend[i] & m_im[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_en[i] = 1'b0; m_im[i] = 1'b0; m_pend[i] = 1'b0; m_mode[i] = 2'b00;
      m_preset[i] = 32'h0; m_count[i] = 32'h0; m_active[i] = 1'b0;
      m_tload[i] = 0; m_n[i] = 0;
    end
  endtask

  task automatic model_edge();
    logic        en0     [NCH];
    logic [1:0]  mode0   [NCH];
    logic [31:0] preset0 [NCH];
    int ch;
    t_edge++;
    for (int i = 0; i < NCH; i++) begin
      en0[i] = m_en[i]; mode0[i] = m_mode[i]; preset0[i] = m_preset[i];
    end
    ch = chan_of(bus.addr);
    if (bus.we && ch >= 0) begin
      if (reg_of(bus.addr, ch) == 0) begin
        m_en[ch]   = bus.wdata[0];
        m_mode[ch] = bus.wdata[2:1];
        m_im[ch]   = bus.wdata[3];
        if (bus.wdata[4]) m_pend[ch] = 1'b0;
      end else if (reg_of(bus.addr, ch) == 1) begin
        m_preset[ch] = bus.wdata;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (!en0[i]) begin
        m_active[i] = 1'b0;
      end else if (!m_active[i]) begin
        m_active[i] = 1'b1;
        m_tload[i]  = t_edge + 1;
      end else if (t_edge >= m_tload[i]) begin
        if (t_edge == m_tload[i]) m_n[i] = longint'(preset0[i]);
        if (t_edge <= m_tload[i] + m_n[i]) m_count[i] = 32'(m_n[i] - (t_edge - m_tload[i]));
        if (t_edge == m_tload[i] + m_n[i] + 1) m_pend[i] = 1'b1;
        if (t_edge == m_tload[i] + m_n[i] + 2) begin
          if (mode0[i] == 2'b01) begin
            m_tload[i] = t_edge + 1;
          end else begin
            m_en[i]     = 1'b0;
            m_active[i] = 1'b0;
          end
        end
      end
    end
  endtask

  initial begin
    t_edge = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else model_edge();
    end
  end

  // Monitor: one scoreboard entry per cycle, checked mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        ntx++;
        $display("txn %0d t=%0t %s addr=%h rdata=%h irq=%b", ntx, $time,
                 e.we ? "wr" : "rd", e.addr, bus.rdata, irq);
        total++;
        if (bus.rdata !== e.rd) begin
          bad++;
          $display("FAIL rdata addr=%h got=%h exp=%h", e.addr, bus.rdata, e.rd);
        end
        total++;
        if (irq !== e.irq) begin
          bad++;
          $display("FAIL irq addr=%h got=%b exp=%b", e.addr, irq, e.irq);
        end
      end
    end
  end

  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input bit use_c, input logic [31:0] c);
    exp_t e;
    @(posedge clk);
    #1;
    bus.we = w; bus.addr = a; bus.wdata = d;
    e.addr = a; e.we = w;
    e.rd   = use_c ? c : model_read(a);
    e.irq  = model_irq();
    sb_q.push_back(e);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    txn(1'b1, a, d, 1'b0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] a);
    txn(1'b0, a, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic rdc(input logic [31:0] a, input logic [31:0] v);
    txn(1'b0, a, 32'h0, 1'b1, v);
  endtask

  // Reset asserted between edges; outputs must be zero before the next clk edge.
  task automatic reset_pulse(input logic [31:0] a);
    exp_t e;
    @(posedge clk);
    #1;
    reset = 1'b0; bus.we = 1'b0; bus.addr = a; bus.wdata = 32'h0;
    #1;
    e.addr = a; e.we = 1'b0; e.rd = 32'h0; e.irq = '0;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout sim time exceeded");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] wd;
    int k, ch;
    reset = 1'b0; bus.we = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    for (int c = 0; c < NCH; c++) for (int r = 0; r < 4; r++) rdc(ra(c, r), 32'h0);
    rdc(32'(ch_base(NCH)), 32'h0);

    // ch0 one-shot, N=5: pend 8 edges after the enabling write
    wr(ra(0, 1), 32'd5);
    wr(ra(0, 0), 32'h9);
    repeat (10) rd(ra(0, 0));
    rdc(ra(0, 0), 32'h18);
    rdc(ra(0, 2), 32'h0);
    wr(ra(0, 0), 32'h10);
    rd(ra(0, 0));

    // ch1 auto-reload, N=3, W1C on each rise
    wr(ra(1, 1), 32'd3);
    wr(ra(1, 0), 32'hB);
    for (int i = 0; i < 40; i++) begin
      if (m_pend[1]) wr(ra(1, 0), 32'h1B);
      else rd(ra(1, 0));
    end
    wr(ra(1, 0), 32'h10);
    repeat (3) rd(ra(1, 0));

    // freeze mid-count, PRESET change only seen at next load
    wr(ra(0, 1), 32'd100);
    wr(ra(0, 0), 32'h1);
    repeat (20) rd(ra(0, 2));
    wr(ra(0, 1), 32'd7);
    repeat (3) rd(ra(0, 2));
    wr(ra(0, 0), 32'h0);
    repeat (5) rd(ra(0, 2));
    rdc(ra(0, 1), 32'd7);
    wr(ra(0, 0), 32'h1);
    repeat (12) rd(ra(0, 2));
    wr(ra(0, 0), 32'h10);
    repeat (3) rd(ra(0, 0));

    // same-edge expiry and W1C, with and without im
    wr(ra(0, 1), 32'd2);
    wr(ra(0, 0), 32'h9);
    repeat (4) rd(ra(0, 2));
    wr(ra(0, 0), 32'h19);
    rdc(ra(0, 0), 32'h19);
    rdc(ra(0, 0), 32'h18);
    wr(ra(0, 0), 32'h10);
    wr(ra(0, 0), 32'h1);
    repeat (4) rd(ra(0, 2));
    wr(ra(0, 0), 32'h11);
    rdc(ra(0, 0), 32'h11);
    rdc(ra(0, 0), 32'h10);
    wr(ra(0, 0), 32'h10);

    // reset mid-count with irq high
    wr(ra(0, 1), 32'd1);
    wr(ra(0, 0), 32'h9);
    wr(ra(1, 1), 32'd50);
    wr(ra(1, 0), 32'h1);
    repeat (10) rd(ra(1, 2));
    reset_pulse(ra(1, 2));
    repeat (6) rdc(ra(1, 2), 32'h0);
    rdc(ra(0, 0), 32'h0);
    rdc(ra(1, 0), 32'h0);

    // randomised phase
    for (int i = 0; i < 1200; i++) begin
      k  = $urandom_range(0, 99);
      ch = $urandom_range(0, NCH - 1);
      if (k < 20) begin
        wd = $urandom;
        wd[0] = ($urandom_range(0, 3) != 0);
        wr(ra(ch, 0), wd);
      end else if (k < 32) begin
        wr(ra(ch, 1), 32'($urandom_range(0, 12)));
      end else if (k < 36) begin
        wr(32'(ch_base(0) - 16 + longint'($urandom_range(0, NCH * 16 + 32))),
           $urandom & 32'h0000_00FF);
      end else begin
        rd(32'(ch_base(0) - 8 + longint'($urandom_range(0, NCH * 16 + 16))));
      end
    end
    @(posedge clk);
    #1 bus.we = 1'b0;

    repeat (3) @(posedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d exp=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
- Parametrised bank of NCH independent 32-bit down-counting timers on the processor bridge bus (PrAddr/PrWD/PrWe/PrRD style).
- Each channel is one-shot or auto-reload, has a sticky pending flag and a maskable interrupt; irq[NCH-1:0] feeds the CPU's HWInt lines.
- Successor to the fixed two-device 0x7F00/0x7F10 map: channel count, base and stride are parameters.

Parameters:
BASE, 32'h0000_7F00, byte address of channel 0
STRIDE, 32'h10, byte distance between channels (power of two, >= 16)
NCH, 2, number of channels (1..6)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; 0 = reset
addr  in  32  bus byte address; addr[1:0] ignored
we  in  1  write strobe, sampled on the rising clk edge
wdata  in  32  write data
rdata  out  32  read data, combinational from addr
irq  out  NCH  per-channel interrupt, irq[i] = pend[i] & im[i]

Behaviour:
Address decode:
- Channel i is hit when BASE+i*STRIDE <= addr <= BASE+i*STRIDE+0xB.
- Register select is addr[3:2]: 0=CTRL (RW), 1=PRESET (RW), 2=COUNT (RO), 3=unmapped.
- Miss or unmapped: rdata=0, writes ignored.
- A write to COUNT is ignored.

CTRL layout:
- [0] en, [2:1] mode (00 one-shot, 01 auto-reload, 1x treated as one-shot), [3] im, [4] pend, [31:5] read 0.
- Write: en, mode and im are loaded from wdata.
- wdata[4]=1 clears pend (write-1-to-clear); wdata[4]=0 leaves pend unchanged.

Reset (reset=0, asynchronous):
- All CTRL, PRESET and COUNT = 0; every FSM in IDLE.
- irq = 0. rdata follows the zeroed registers.

Per-channel FSM: IDLE, LOAD, CNT, INT. Transitions happen on the clk edge and use register values as they stand before that edge.
- IDLE: if en=1, go to LOAD.
- LOAD: count <= PRESET, go to CNT.
- CNT: if count != 0, count <= count-1; if count == 0, go to INT and set pend <= 1.
- INT: one-shot: en <= 0, go to IDLE. Auto-reload: go to LOAD.
- en=0 in any state: go to IDLE on the next edge, and this has priority. COUNT holds its value (frozen, not cleared).

Latency:
- Write of en=1 at edge E0 gives IDLE->LOAD at E1, COUNT=PRESET=N at E2, COUNT=0 at E2+N, pend=1 at E2+N+1.
- PRESET=0 behaves the same with N=0: pend=1 at E3.
- Auto-reload period is N+3 cycles between pend-set edges.

Boundary cases:
- A PRESET write while counting does not affect COUNT until the next LOAD.
- A CTRL write with en=1 while in LOAD/CNT/INT does not restart the channel. mode and im update immediately; the new mode applies at the next INT.
- pend set (INT entry) and W1C on the same edge: set wins.
- A CTRL write in INT with en=1 in one-shot mode: the FSM's en<=0 wins and the channel stops.
- irq is level, held until pend is cleared or im=0, independent of en.
- Channels are fully independent; simultaneous expiry raises multiple irq bits on the same edge.
- Reset asserted mid-count: immediate return to reset values. Counting restarts only after software sets en again.

Test Plan:
- Reset then read every register of every channel -> all read 0, irq=0; read at BASE+0xC and at BASE+NCH*STRIDE -> 0.
- ch0: PRESET=5, CTRL=0x9 (en, one-shot, im) -> pend/irq[0] rise exactly 8 cycles after the CTRL write edge. CTRL then reads 0x18 (en cleared). COUNT reads 0. Writing CTRL=0x10 drops irq[0] next edge.
- ch1: PRESET=3, CTRL=0xB (auto-reload, im) -> irq[1] first rises 6 cycles after the write. Clearing pend (CTRL=0x1B) on each rise gives the next rise every 6 cycles. ch0 stays 0 throughout.
- Mid-count: PRESET=100, en=1; after 20 cycles write CTRL=0 -> COUNT freezes at its current value. PRESET write 7 during counting -> no effect until re-enable.
- Same-edge pend set and W1C: place the W1C write on the INT-entry edge -> pend reads 1 afterwards. Also with im=0 -> pend=1 but irq=0.
- Assert reset low for 1 cycle mid-count with irq high -> irq=0 and COUNT=0 asynchronously (before the next clk edge); no further activity after release.
